// File: rtl/aes128_pkg.sv
// AES-128 tables and byte-level transforms shared by the iterative inverse cipher.
// Bytes are column-major: byte 0 is [127:120], state[r][c] is byte r+4c.
package aes128_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^
           (m[2] ? b4 : 8'h00) ^ (m[3] ? b8 : 8'h00);
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // Row r rotates right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
      o[119-32*c -: 8] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
      o[111-32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
      o[103-32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_inv_cipher_iter_if.sv
// Block in/out handshake bus of the inverse cipher; slave = core, master = source/sink.
interface aes128_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_text;
  logic [127:0] round_key_10;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain_text;
  logic         iv_load;
  logic [127:0] iv;

  modport master (
    output in_valid, cipher_text, round_key_10, out_ready, iv_load, iv,
    input  in_ready, out_valid, plain_text
  );

  modport slave (
    input  in_valid, cipher_text, round_key_10, out_ready, iv_load, iv,
    output in_ready, out_valid, plain_text
  );
endinterface

// File: rtl/aes128_inv_round.sv
// One combinational inverse round: steps key rk[rnd+1] -> rk[rnd], then applies round rnd.
// No latency (pure logic); no flow control.
module aes128_inv_round
  import aes128_pkg::*;
(
  input  state_t     state,
  input  state_t     key,
  input  logic [3:0] rnd,
  input  logic       is_last,
  output state_t     next_state,
  output state_t     prev_key
);

  word_t  w0, w1, w2, w3, n0, n1, n2, n3;
  state_t keyed;

  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    n3 = w3 ^ w2;
    n2 = w2 ^ w1;
    n1 = w1 ^ w0;
    // Rcon index is that of the key being stepped from, i.e. rnd+1.
    n0 = w0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rcon_of(rnd + 4'd1), 24'h000000};
    prev_key   = {n0, n1, n2, n3};
    keyed      = inv_sub_bytes(inv_shift_rows(state)) ^ prev_key;
    next_state = is_last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 InvCipher, ROUNDS_PER_CYCLE rounds per clock; out_valid 10/ROUNDS_PER_CYCLE clocks after accept.
// Result held until out_ready; in_ready follows out_ready in DONE. CBC chaining under AES_INV_CBC_EN.
module aes128_inv_cipher_iter
  import aes128_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic                      clk_sys,
  input logic                      rst_n,
  aes128_inv_cipher_iter_if.slave  bus
);

  localparam int NUM_ITER = 10 / (ROUNDS_PER_CYCLE > 0 ? ROUNDS_PER_CYCLE : 1);

  // Only exact divisors of ten keep the round-0 step aligned to the last stage.
  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE * NUM_ITER != 10) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  fsm_t       fsm;
  logic       armed;
  state_t     st_q, key_q, plain_q, pt_next;
  logic [3:0] rnd_q;
  logic       out_valid_q;
  logic       in_ready_int, accept, last_iter;

  state_t st_c  [ROUNDS_PER_CYCLE+1];
  state_t key_c [ROUNDS_PER_CYCLE+1];

  assign st_c[0]  = st_q;
  assign key_c[0] = key_q;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_rnd
    aes128_inv_round u_round (
      .state      (st_c[k]),
      .key        (key_c[k]),
      .rnd        (rnd_q - 4'(k)),
      .is_last    (rnd_q == 4'(k)),
      .next_state (st_c[k+1]),
      .prev_key   (key_c[k+1])
    );
  end

  assign in_ready_int = armed && ((fsm == IDLE) || (fsm == DONE && bus.out_ready));
  assign accept       = bus.in_valid && in_ready_int;
  assign last_iter    = (rnd_q == 4'(ROUNDS_PER_CYCLE - 1));

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_q;
  assign bus.plain_text = plain_q;

`ifdef AES_INV_CBC_EN
  state_t chain_q, mask_q;

  assign pt_next = st_c[ROUNDS_PER_CYCLE] ^ mask_q;

  // mask_q is the chain value belonging to the block in flight.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      mask_q  <= '0;
    end else begin
      if (bus.iv_load && fsm != RUN) chain_q <= bus.iv;
      else if (accept)               chain_q <= bus.cipher_text;
      if (accept) mask_q <= bus.iv_load ? bus.iv : chain_q;
    end
  end
`else
  logic unused_cbc;

  assign pt_next    = st_c[ROUNDS_PER_CYCLE];
  assign unused_cbc = ^{bus.iv_load, bus.iv};
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      armed       <= 1'b0;
      st_q        <= '0;
      key_q       <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      plain_q     <= '0;
    end else begin
      armed <= 1'b1;
      case (fsm)
        RUN: begin
          st_q  <= st_c[ROUNDS_PER_CYCLE];
          key_q <= key_c[ROUNDS_PER_CYCLE];
          rnd_q <= rnd_q - 4'(ROUNDS_PER_CYCLE);
          if (last_iter) begin
            plain_q     <= pt_next;
            out_valid_q <= 1'b1;
            fsm         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            fsm         <= IDLE;
          end
        end
        default: ;
      endcase
      // An accept in DONE overrides the return to IDLE (back-to-back restart).
      if (accept) begin
        st_q  <= bus.cipher_text ^ bus.round_key_10;
        key_q <= bus.round_key_10;
        rnd_q <= 4'd9;
        fsm   <= RUN;
      end
    end
  end

endmodule
